glitch_injector: RTL and testbench

GLITCH_INJECTOR -- requirements
Module: glitch_injector

---
 rtl/glitch_injector.sv | 71 +++++++
 tb/tb_glitch_injector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/glitch_injector.sv
// Fault-injection stage: forwards in XOR (LFSR, fixed or zero mask) to a register. Optional counter: GLITCH_INJECTOR_COUNT_EN.
// Latency 1 cycle; no backpressure, a new word is accepted and emitted every cycle.
module glitch_injector #(
    parameter int               WIDTH     = 8,
    parameter int               SEED      = 17,
    parameter logic [WIDTH-1:0] SPEC_MASK = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             enable_specific,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
`ifdef GLITCH_INJECTOR_COUNT_EN
    output logic [15:0]      glitch_count,
`endif
    output logic             glitched
);

    // An all-zero LFSR would lock up, so a zero seed is forced to 1.
    localparam logic [15:0] SEED16    = 16'(SEED);
    localparam logic [15:0] SEED_INIT = (SEED16 == 16'h0000) ? 16'h0001 : SEED16;

    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [WIDTH-1:0] mask;
    logic             mask_nz;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // enable wins over enable_specific; the mask uses the pre-advance LFSR.
    always_comb begin
        mask = '0;
        if (enable) begin
            mask = lfsr[WIDTH-1:0];
        end else if (enable_specific) begin
            mask = SPEC_MASK;
        end
    end

    assign mask_nz = (mask != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED_INIT;
        end else if (enable) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out      <= '0;
            glitched <= 1'b0;
        end else begin
            out      <= in ^ mask;
            glitched <= mask_nz;
        end
    end

`ifdef GLITCH_INJECTOR_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_count <= 16'h0000;
        end else if (mask_nz && (glitch_count != 16'hFFFF)) begin
            glitch_count <= glitch_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_glitch_injector.sv
// Bench for glitch_injector (WIDTH=8, SEED=17): directed vectors plus a per-cycle reference model.
module tb_glitch_injector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       enable_specific = 1'b0;
    logic [7:0] in = 8'hAA;
    logic [7:0] out;
    logic       glitched;
`ifdef GLITCH_INJECTOR_COUNT_EN
    logic [15:0] glitch_count;
`endif

    int checks = 0;
    int errors = 0;

    glitch_injector #(.WIDTH(8), .SEED(17), .SPEC_MASK(8'h01)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .enable_specific (enable_specific),
        .in              (in),
        .out             (out),
`ifdef GLITCH_INJECTOR_COUNT_EN
        .glitch_count    (glitch_count),
`endif
        .glitched        (glitched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the LFSR is treated as an integer sequence generator.
    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s * 2) & 32'hFFFF) | fb;
    endfunction

    int m_lfsr;
    int m_out;
    int m_gl;
    int m_cnt;

    always @(posedge clk or negedge reset) begin
        int m;
        if (!reset) begin
            m_lfsr = 17;
            m_out  = 0;
            m_gl   = 0;
            m_cnt  = 0;
        end else begin
            if (enable)               m = m_lfsr % 256;
            else if (enable_specific) m = 1;
            else                      m = 0;
            m_out = int'(in) ^ m;
            m_gl  = (m != 0) ? 1 : 0;
            if (m != 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (enable) m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        chk("model_out", 32'(out), 32'(m_out));
        chk("model_glitched", 32'(glitched), 32'(m_gl));
`ifdef GLITCH_INJECTOR_COUNT_EN
        chk("model_count", 32'(glitch_count), 32'(m_cnt));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] o, input logic g);
        cyc();
        chk({name, "_out"}, 32'(out), 32'(o));
        chk({name, "_glitched"}, 32'(glitched), 32'(g));
    endtask

    initial begin
        #2 reset = 1'b0;
        // Reset held with the clock running.
        repeat (3) begin
            cyc();
            chk("rst_out", 32'(out), 32'h00);
            chk("rst_glitched", 32'(glitched), 32'h0);
        end
        chk("rst_lfsr", 32'(dut.lfsr), 32'h0011);

        reset = 1'b1;
        expect_out("pass0", 8'hAA, 1'b0);
        expect_out("pass1", 8'hAA, 1'b0);
        chk("pass_lfsr", 32'(dut.lfsr), 32'h0011);
        chk("model_lfsr_pin", 32'(m_lfsr), 32'h0011);

        enable = 1'b1;
        expect_out("rnd0", 8'hBB, 1'b1);
        chk("model_rnd0_pin", 32'(m_out), 32'hBB);
        expect_out("rnd1", 8'h88, 1'b1);
        expect_out("rnd2", 8'hEE, 1'b1);
        chk("model_rnd2_pin", 32'(m_out), 32'hEE);

        enable = 1'b0;
        enable_specific = 1'b1;
        expect_out("spec0", 8'hAB, 1'b1);
        expect_out("spec1", 8'hAB, 1'b1);
        chk("spec_lfsr_frozen", 32'(dut.lfsr), 32'h0088);

        enable_specific = 1'b0;
        enable = 1'b1;
        expect_out("rnd3", 8'h22, 1'b1);
        expect_out("rnd4", 8'hBA, 1'b1);

        // Asynchronous reset pulse between edges.
        #2 reset = 1'b0;
        #1;
        chk("async_out", 32'(out), 32'h00);
        chk("async_glitched", 32'(glitched), 32'h0);
        chk("async_lfsr", 32'(dut.lfsr), 32'h0011);
        #1 reset = 1'b1;

        enable_specific = 1'b1;
        expect_out("both0", 8'hBB, 1'b1);
        expect_out("both1", 8'h88, 1'b1);
        expect_out("both2", 8'hEE, 1'b1);

        enable = 1'b0;
        enable_specific = 1'b0;
        in = 8'h5C;
        expect_out("pass2", 8'h5C, 1'b0);
        in = 8'hAA;
        expect_out("pass3", 8'hAA, 1'b0);

`ifdef GLITCH_INJECTOR_COUNT_EN
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        enable = 1'b1;
        repeat (3) cyc();
        enable = 1'b0;
        repeat (2) cyc();
        chk("count_three", 32'(glitch_count), 32'h0003);
        force dut.glitch_count = 16'hFFFF;
        #1 release dut.glitch_count;
        enable = 1'b1;
        cyc();
        cyc();
        chk("count_saturate", 32'(glitch_count), 32'hFFFF);
        enable = 1'b0;
        // Resync the model after the forced value.
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        cyc();
`endif

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
